// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the memory-stage load/store unit.
//   - func3 encodings for RV32I loads and stores
//   - lsu_state_e: request/grant/response FSM states
//   - access_size(): access width decoded from func3[1:0]
//   - misaligned(): alignment check for a given size code and address
//   - trunc_lo(): low address bits with misaligned bits cleared
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // func3[1:0] alone fixes the width for both loads and stores; the
    // unused codes (x11, 11x) fall into the word case.
    function automatic logic [1:0] access_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] f3_lo, input logic [1:0] addr_lo);
        case (access_size(f3_lo))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] trunc_lo(input logic [1:0] f3_lo, input logic [1:0] addr_lo);
        case (access_size(f3_lo))
            SZ_HALF: return {addr_lo[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load formatter.
// Picks the byte or halfword lane selected by addr_lo out of the raw bus
// word and sign- or zero-extends it according to func3.
//   rdata   in  32  raw word from the data bus
//   addr_lo in  2   byte offset (already truncated for the access size)
//   func3   in  3   load size/sign encoding
//   data    out 32  formatted load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    assign is_unsigned = func3[2];

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (access_size(func3[1:0]))
            SZ_BYTE: data = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit with a single-outstanding
// request/grant/response bus.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to drop misaligned accesses
// and pulse misaligned_o; otherwise the low address bits are truncated and
// the access proceeds.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   mem_read, mem_write  registered load/store request (both set = store)
//   func3                RV32I size/sign encoding
//   addr, wdata          byte address and store data
//   stall_o              holds upstream pipeline registers while busy
//   rdata_o              formatted load data (registered)
//   load_valid_o         one-cycle pulse when rdata_o updates
//   misaligned_o         registered misaligned-access pulse
//   bus_req/we/addr/be/wdata  request channel
//   bus_gnt              request accepted
//   bus_rvalid/rdata     read response channel
//   state_o              current FSM state (debug)
//
// Handshake: a request is presented with bus_req=1 and all bus_* outputs
// stable; it is accepted in the cycle bus_gnt is high. Read data is
// accepted only in WAIT when bus_rvalid is high; bus_rvalid elsewhere is
// ignored.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              load_valid_o,
    output logic              misaligned_o,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        state_o
);

    lsu_state_e  state;
    logic        op;
    logic        is_store;
    logic        legal;
    logic        issue;
    logic [1:0]  size;
    logic [1:0]  lo;
    logic [DATA_W-1:0] load_data;

    assign op       = mem_read | mem_write;
    assign is_store = mem_write;
    assign size     = access_size(func3[1:0]);
    assign lo       = trunc_lo(func3[1:0], addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_detect;
    assign mis_detect = misaligned(func3[1:0], addr[1:0]);
    assign legal      = !mis_detect;
`else
    assign legal        = 1'b1;
    assign misaligned_o = 1'b0;
`endif

    // Upstream holds mem_*/func3/addr/wdata while stall_o is high, so bus
    // outputs derived from them stay stable through REQ and WAIT.
    assign issue   = ((state == IDLE) && op && legal) || (state == REQ);
    assign bus_req = !reset && issue;
    assign stall_o = !reset && (issue || (state == WAIT));

    assign bus_we   = is_store;
    assign bus_addr = {addr[ADDR_W-1:2], 2'b00};
    assign state_o  = state;

    always_comb begin
        bus_be    = 4'b1111;
        bus_wdata = wdata;
        if (is_store) begin
            case (size)
                SZ_BYTE: begin
                    bus_be    = 4'b0001 << lo;
                    bus_wdata = {4{wdata[7:0]}};
                end
                SZ_HALF: begin
                    bus_be    = 4'b0011 << lo;
                    bus_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    bus_be    = 4'b1111;
                    bus_wdata = wdata;
                end
            endcase
        end
    end

    lsu_load_align u_load_align (
        .rdata   (bus_rdata),
        .addr_lo (lo),
        .func3   (func3),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rdata_o      <= '0;
            load_valid_o <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_o <= 1'b0;
`endif
        end else begin
            load_valid_o <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (op && legal) begin
                        if (bus_gnt) state <= is_store ? DONE : WAIT;
                        else         state <= REQ;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    // Misaligned op is dropped: no request, no stall.
                    if (op && mis_detect) misaligned_o <= 1'b1;
`endif
                end
                REQ: begin
                    if (bus_gnt) state <= is_store ? DONE : WAIT;
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        rdata_o      <= load_data;
                        load_valid_o <= 1'b1;
                        state        <= DONE;
                    end
                end
                // DONE releases the stall for one cycle so the pipeline
                // register advances before the op could be seen again.
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-stage load/store unit sitting directly downstream of the execute/memory pipeline control register. Consumes the registered `mem_read`, `mem_write` and `func3` controls plus the ALU address and store data. Drives a single-outstanding request/grant/response data bus with byte enables and returns sign/zero-extended load data to write-back. Raises `stall_o` back to the pipeline registers while an access is in flight.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32 (4 byte lanes)
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `mem_read`  in  1  load request from the pipeline register
- `mem_write`  in  1  store request from the pipeline register
- `func3`  in  3  access size/sign (RV32I load/store encoding)
- `addr`  in  ADDR_W  byte address from the ALU
- `wdata`  in  DATA_W  store data (rs2)
- `stall_o`  out  1  hold all upstream pipeline registers
- `rdata_o`  out  DATA_W  formatted load data, registered
- `load_valid_o`  out  1  one-cycle pulse when `rdata_o` is updated
- `misaligned_o`  out  1  misaligned-access pulse (see Configuration)
- `bus_req`  out  1  request valid
- `bus_we`  out  1  1 = write
- `bus_addr`  out  ADDR_W  word-aligned address `{addr[ADDR_W-1:2], 2'b00}`
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  DATA_W  lane-replicated store data
- `bus_gnt`  in  1  request accepted
- `bus_rvalid`  in  1  read data valid
- `bus_rdata`  in  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `op = mem_read | mem_write`. If `op` is set and the access is legal, `bus_req` = 1 and `stall_o` = 1, both combinational in the same cycle.
  - `bus_gnt` with a store goes to DONE.
  - `bus_gnt` with a load goes to WAIT.
  - No `bus_gnt` goes to REQ.
- REQ: `bus_req` = 1, `stall_o` = 1, and all bus outputs are held stable until `bus_gnt`. Exits follow the IDLE rules.
- WAIT: `bus_req` = 0, `stall_o` = 1. On `bus_rvalid`, the formatted data is registered into `rdata_o`, `load_valid_o` pulses next cycle, and the FSM goes to DONE.
- DONE: `stall_o` = 0 and no request, so the pipeline register advances. Return to IDLE unconditionally. This prevents re-issue of the still-present op.
- `mem_read` and `mem_write` both set: treated as a store.
- `bus_rvalid` outside WAIT is ignored.
- Store formatting (`func3` 000 SB, 001 SH, 010 SW):
  - `bus_be` = `4'b0001 << addr[1:0]`, `4'b0011 << addr[1:0]`, or `4'b1111`.
  - `bus_wdata` = byte replicated ×4, half replicated ×2, or full word.
  - `func3` 011/11x on a store is treated as SW.
- Load formatting: select the byte or half by `addr[1:0]`.
  - 000 LB: sign-extend.
  - 001 LH: sign-extend.
  - 010 LW: full word.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
  - Other codes: treated as LW.
  - For loads, `bus_be` = 4'b1111.
- Misaligned: LH/LHU/SH with `addr[0]` = 1, or word access with `addr[1:0]` ≠ 0.

## Timing
- Reset values: state IDLE, `rdata_o` = 0, `load_valid_o` = 0, `misaligned_o` = 0.
- While `reset` is high: `bus_req` = 0 and `stall_o` = 0.
- Reset during REQ or WAIT abandons the access. A late `bus_rvalid` after reset is ignored.
- Zero-wait bus (`gnt` same cycle as `req`, `rvalid` one cycle later):
  - Load: 3 cycles (IDLE, WAIT, DONE) with `stall_o` = 1, 1, 0.
  - Store: 2 cycles (IDLE, DONE).
- Each cycle of `gnt` delay adds one REQ cycle. Each cycle of `rvalid` delay adds one WAIT cycle.
- `rdata_o` is valid from the DONE cycle and holds until the next load completes.
- Back-to-back ops: the second op is issued in the IDLE cycle directly after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned op in IDLE issues no bus request.
  - `misaligned_o` pulses for one cycle (registered, the cycle after detection).
  - `stall_o` = 0 and the FSM stays in IDLE, so the op is dropped.
- Not defined:
  - `misaligned_o` is tied to 0.
  - The address is truncated: the low bit is cleared for halfwords, and both low bits for words.
  - The access proceeds normally.

## Structure
- `lsu_pkg`:
  - `func3` localparams (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - `lsu_state_e` enum (IDLE/REQ/WAIT/DONE).
  - A `misaligned()` function.
- Sub-module `lsu_load_align`: combinational byte/half extraction and extension from `bus_rdata`, `addr[1:0]` and `func3`. It is instantiated once, ahead of the `rdata_o` register.

## Test plan
- LW `addr` = 0x100, zero-wait bus, `bus_rdata` = 0xDEADBEEF → `bus_be` = 0xF, `stall_o` sequence 1,1,0, `rdata_o` = 0xDEADBEEF, `load_valid_o` pulses in the DONE cycle.
- LB `addr` = 0x103, `bus_rdata` = 0x80112233 → `rdata_o` = 0xFFFFFF80. LBU at the same address → `rdata_o` = 0x00000080.
- SH `addr` = 0x202, `wdata` = 0x0000ABCD, `gnt` delayed 3 cycles → `bus_be` = 0xC, `bus_wdata` = 0xABCDABCD held stable, `stall_o` high for 4 cycles, then DONE.
- LW `addr` = 0x101:
  - With `LSU_MISALIGN_TRAP_EN` → no `bus_req`, `misaligned_o` pulse, `stall_o` = 0.
  - Without → `bus_addr` = 0x100 and a normal load.
- Reset asserted in WAIT, `rvalid` arrives a cycle later → state IDLE, `rdata_o` = 0, no `load_valid_o`.
- SW then LW back-to-back, both held by the upstream stall → exactly one bus request each, second request in the cycle after the first DONE.
